// File: rtl/vga_timing_gen_param.sv
// ============================================================================
// Module   : vga_timing_gen_param
// Brief    : Parametrised VGA/VESA raster timing generator with look-ahead
//            pixel request. Optional macro VTG_LOOKAHEAD_EN builds the lead
//            counter; without it req mirrors de.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen_param #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNCP   = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNCP   = 2,
  parameter int   V_BP      = 33,
  parameter logic HS_POL    = 1'b0,
  parameter logic VS_POL    = 1'b0,
  parameter int   CW        = 12,
  parameter int   LOOKAHEAD = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          h_sync,
  output logic          v_sync,
  output logic          de,
  output logic [CW-1:0] x_pos,
  output logic [CW-1:0] y_pos,
  output logic          sol,
  output logic          sof,
  output logic          eof,
  output logic [15:0]   frame_cnt,
  output logic          req,
  output logic [CW-1:0] req_x,
  output logic [CW-1:0] req_y
);

  localparam int c_h_total = H_ACTIVE + H_FP + H_SYNCP + H_BP;
  localparam int c_v_total = V_ACTIVE + V_FP + V_SYNCP + V_BP;

  localparam logic [CW-1:0] c_h_last   = CW'(c_h_total - 1);
  localparam logic [CW-1:0] c_v_last   = CW'(c_v_total - 1);
  localparam logic [CW-1:0] c_h_act    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] c_v_act    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] c_hs_start = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] c_hs_end   = CW'(H_ACTIVE + H_FP + H_SYNCP);
  localparam logic [CW-1:0] c_vs_start = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] c_vs_end   = CW'(V_ACTIVE + V_FP + V_SYNCP);

  if ((LOOKAHEAD < 0) || (LOOKAHEAD > H_FP + H_SYNCP + H_BP - 1)) begin : g_la_range_err
    $error("vga_timing_gen_param: LOOKAHEAD %0d out of range", LOOKAHEAD);
  end

  // Main counter starts LOOKAHEAD pixels behind the lead; both sit in the
  // same blanking line so no vertical borrow is needed.
`ifdef VTG_LOOKAHEAD_EN
  localparam logic [CW-1:0] c_h_main_rst = CW'(c_h_total - 1 - LOOKAHEAD);
`else
  localparam logic [CW-1:0] c_h_main_rst = c_h_last;
`endif

  function automatic logic [2*CW-1:0] f_step(input logic [CW-1:0] h, input logic [CW-1:0] v);
    logic [CW-1:0] hn;
    logic [CW-1:0] vn;
    hn = h + 1'b1;
    vn = v;
    if (h == c_h_last) begin
      hn = '0;
      vn = (v == c_v_last) ? '0 : v + 1'b1;
    end
    return {vn, hn};
  endfunction

  logic [CW-1:0] r_h, r_v;
  logic [CW-1:0] w_h_nxt, w_v_nxt;
  logic          w_act;

  logic          r_h_sync, r_v_sync, r_de, r_sol, r_sof, r_eof;
  logic [CW-1:0] r_x, r_y;
  logic [15:0]   r_frame_cnt;

  assign {w_v_nxt, w_h_nxt} = f_step(r_h, r_v);
  assign w_act = (w_h_nxt < c_h_act) && (w_v_nxt < c_v_act);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h         <= c_h_main_rst;
      r_v         <= c_v_last;
      r_h_sync    <= ~HS_POL;
      r_v_sync    <= ~VS_POL;
      r_de        <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_sol       <= 1'b0;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_sol <= 1'b0;
      r_sof <= 1'b0;
      r_eof <= 1'b0;
      if (en) begin
        r_h      <= w_h_nxt;
        r_v      <= w_v_nxt;
        r_de     <= w_act;
        r_x      <= w_act ? w_h_nxt : '0;
        r_y      <= w_act ? w_v_nxt : '0;
        r_h_sync <= ((w_h_nxt >= c_hs_start) && (w_h_nxt < c_hs_end)) ? HS_POL : ~HS_POL;
        r_v_sync <= ((w_v_nxt >= c_vs_start) && (w_v_nxt < c_vs_end)) ? VS_POL : ~VS_POL;
        r_sol    <= (w_h_nxt == '0) && (w_v_nxt < c_v_act);
        r_sof    <= (w_h_nxt == '0) && (w_v_nxt == '0);
        r_eof    <= (w_h_nxt == c_h_act - 1'b1) && (w_v_nxt == c_v_act - 1'b1);
        if ((w_h_nxt == '0) && (w_v_nxt == '0)) begin
          r_frame_cnt <= r_frame_cnt + 16'd1;
        end
      end
    end
  end

  assign h_sync    = r_h_sync;
  assign v_sync    = r_v_sync;
  assign de        = r_de;
  assign x_pos     = r_x;
  assign y_pos     = r_y;
  assign sol       = r_sol;
  assign sof       = r_sof;
  assign eof       = r_eof;
  assign frame_cnt = r_frame_cnt;

`ifdef VTG_LOOKAHEAD_EN
  logic [CW-1:0] r_hr, r_vr;
  logic [CW-1:0] w_hr_nxt, w_vr_nxt;
  logic          w_req_act;
  logic          r_req;
  logic [CW-1:0] r_req_x, r_req_y;

  assign {w_vr_nxt, w_hr_nxt} = f_step(r_hr, r_vr);
  assign w_req_act = (w_hr_nxt < c_h_act) && (w_vr_nxt < c_v_act);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hr    <= c_h_last;
      r_vr    <= c_v_last;
      r_req   <= 1'b0;
      r_req_x <= '0;
      r_req_y <= '0;
    end else if (en) begin
      r_hr    <= w_hr_nxt;
      r_vr    <= w_vr_nxt;
      r_req   <= w_req_act;
      r_req_x <= w_req_act ? w_hr_nxt : '0;
      r_req_y <= w_req_act ? w_vr_nxt : '0;
    end
  end

  assign req   = r_req;
  assign req_x = r_req_x;
  assign req_y = r_req_y;
`else
  assign req   = r_de;
  assign req_x = r_x;
  assign req_y = r_y;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen_param.sv
// ============================================================================
// Module   : tb_vga_timing_gen_param
// Brief    : Randomised bench for vga_timing_gen_param against a linear
//            raster-index reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_gen_param;

  localparam int c_cw    = 12;
  localparam int c_la    = 2;
  localparam int c_ht    = 14;
  localparam int c_vt    = 8;
  localparam int c_total = c_ht * c_vt;
`ifdef VTG_LOOKAHEAD_EN
  localparam int c_la_eff = c_la;
`else
  localparam int c_la_eff = 0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en  = 1'b0;
  logic            h_sync, v_sync, de, sol, sof, eof, req;
  logic [c_cw-1:0] x_pos, y_pos, req_x, req_y;
  logic [15:0]     frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  vga_timing_gen_param #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNCP(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNCP(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(c_cw), .LOOKAHEAD(c_la)
  ) u_dut (
    .clk(clk), .rst(rst), .en(en),
    .h_sync(h_sync), .v_sync(v_sync), .de(de),
    .x_pos(x_pos), .y_pos(y_pos),
    .sol(sol), .sof(sof), .eof(eof), .frame_cnt(frame_cnt),
    .req(req), .req_x(req_x), .req_y(req_y)
  );

  always #5 clk = ~clk;

  task automatic t_check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model state: enabled edges since reset, and whether the last edge was enabled.
  int n_en    = 0;
  bit last_en = 1'b0;

  task automatic t_compare();
    int mi, li, mh, mv, lh, lv, fc;
    bit m_act, l_act;
    if (n_en == 0) begin
      t_check("h_sync", 32'(h_sync), 32'd1);
      t_check("v_sync", 32'(v_sync), 32'd1);
      t_check("de",     32'(de),     32'd0);
      t_check("x_pos",  32'(x_pos),  32'd0);
      t_check("y_pos",  32'(y_pos),  32'd0);
      t_check("sol",    32'(sol),    32'd0);
      t_check("sof",    32'(sof),    32'd0);
      t_check("eof",    32'(eof),    32'd0);
      t_check("frame",  32'(frame_cnt), 32'd0);
      t_check("req",    32'(req),    32'd0);
      t_check("req_x",  32'(req_x),  32'd0);
      t_check("req_y",  32'(req_y),  32'd0);
      return;
    end
    mi = (c_total - 1 - c_la_eff + n_en) % c_total;
    li = (c_total - 1 + n_en) % c_total;
    mh = mi % c_ht;  mv = mi / c_ht;
    lh = li % c_ht;  lv = li / c_ht;
    m_act = (mh < 8) && (mv < 4);
    l_act = (lh < 8) && (lv < 4);
    fc = (n_en >= c_la_eff + 1) ? ((n_en - c_la_eff - 1) / c_total + 1) % 65536 : 0;
    t_check("h_sync", 32'(h_sync), (mh >= 10 && mh < 13) ? 32'd0 : 32'd1);
    t_check("v_sync", 32'(v_sync), (mv >= 5 && mv < 7) ? 32'd0 : 32'd1);
    t_check("de",     32'(de),     32'(m_act));
    t_check("x_pos",  32'(x_pos),  m_act ? 32'(mh) : 32'd0);
    t_check("y_pos",  32'(y_pos),  m_act ? 32'(mv) : 32'd0);
    t_check("sol",    32'(sol),    32'(last_en && mh == 0 && mv < 4));
    t_check("sof",    32'(sof),    32'(last_en && mi == 0));
    t_check("eof",    32'(eof),    32'(last_en && mh == 7 && mv == 3));
    t_check("frame",  32'(frame_cnt), 32'(fc));
    t_check("req",    32'(req),    32'(l_act));
    t_check("req_x",  32'(req_x),  l_act ? 32'(lh) : 32'd0);
    t_check("req_y",  32'(req_y),  l_act ? 32'(lv) : 32'd0);
  endtask

  // One clock: drive at negedge, advance model at posedge, sample 1 time unit later.
  task automatic t_cycle(input bit r, input bit e);
    @(negedge clk);
    rst = r;
    en  = e;
    @(posedge clk);
    if (r) begin
      n_en    = 0;
      last_en = 1'b0;
    end else if (e) begin
      n_en++;
      last_en = 1'b1;
    end else begin
      last_en = 1'b0;
    end
    #1;
    t_compare();
  endtask

  initial begin
    // Reset for three cycles, then free-run beyond two full frames.
    for (int i = 0; i < 3; i++) t_cycle(1'b1, 1'b0);
    for (int i = 0; i < 3 * c_total; i++) t_cycle(1'b0, 1'b1);

    // Enable pattern 1,0,0,1 repeated.
    for (int i = 0; i < 4 * c_total; i++) t_cycle(1'b0, (i % 4 == 0) || (i % 4 == 3));

    // Run to the active pixel (5,2) and reset there mid-frame.
    for (int i = 0; i < 2 * c_total; i++) begin
      if (de && x_pos == 5 && y_pos == 2) break;
      t_cycle(1'b0, 1'b1);
    end
    t_check("mid_rst_pos", 32'({x_pos, y_pos}), 32'({12'd5, 12'd2}));
    t_cycle(1'b1, 1'b1);
    for (int i = 0; i < c_total + 10; i++) t_cycle(1'b0, 1'b1);

    // Random enable with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      t_cycle(($urandom_range(0, 399) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
